arm_serial_out_buffer: RTL and testbench

- Parallel-to-serial output buffer: captures a 7-bit address A and an 8-bit data word D on a Go strobe.
- Shifts the 15-bit frame {A,D} out MSB-first on OutD, with a companion strobe clock on OutC.
- Sits between a parallel register interface and an external two-wire serial sink.
- Instantiated positionally as (OutD, OutC, D, A, Go, clk_in, reset_n); the implementation keeps this port order.

---
 rtl/arm_serial_out_buffer.sv | 70 +++++++
 tb/tb_arm_serial_out_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/arm_serial_out_buffer.sv
// Parallel-to-serial output buffer: latches {A,D} on Go and shifts it out MSB-first
// on OutD, with a one-cycle-wide strobe on OutC for every bit.
module arm_serial_out_buffer #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  output logic              OutD,
  output logic              OutC,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] A,
  input  logic              Go,
  input  logic              clk_in,
  input  logic              reset_n
);

  localparam int FRAME_BITS = ADDR_W + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                  state, state_nxt;
  logic [FRAME_BITS-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]        bitcnt, bitcnt_nxt;

  // reset_n is active-high despite its name.
  always_ff @(posedge clk_in) begin
    if (reset_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      OutD   <= 1'b0;
      OutC   <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
      // Outputs are registered from the next state so they line up with it.
      OutD   <= (state_nxt != IDLE) & shreg_nxt[FRAME_BITS-1];
      OutC   <= (state_nxt == HIGH);
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    case (state)
      IDLE: begin
        if (Go) begin
          shreg_nxt  = {A, D};
          bitcnt_nxt = '0;
          state_nxt  = LOW;
        end
      end
      LOW:  state_nxt = HIGH;
      HIGH: begin
        if (bitcnt == LAST_BIT) begin
          state_nxt = IDLE;
        end else begin
          shreg_nxt  = {shreg[FRAME_BITS-2:0], 1'b0};
          bitcnt_nxt = bitcnt + 1'b1;
          state_nxt  = LOW;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arm_serial_out_buffer.sv
// Bench for arm_serial_out_buffer: vector table, directed corner sequences and random
// traffic, all compared against a queue-based model of the serial frame.
module tb_arm_serial_out_buffer;

  logic       clk_in = 1'b0;
  logic       reset_n, Go, OutD, OutC;
  logic [7:0] D;
  logic [6:0] A;

  always #5 clk_in = ~clk_in;

  arm_serial_out_buffer dut (
    .OutD(OutD), .OutC(OutC), .D(D), .A(A), .Go(Go), .clk_in(clk_in), .reset_n(reset_n)
  );

  int checks = 0;
  int errors = 0;

  // Model: a frame is 30 (data, strobe) pairs queued when Go is seen while idle.
  bit q_d[$];
  bit q_c[$];
  bit in_frame = 1'b0;
  bit m_d, m_c;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic go, input logic [6:0] a, input logic [7:0] d);
    logic [14:0] f;
    reset_n = rst; Go = go; A = a; D = d;
    @(posedge clk_in);
    if (rst) begin
      q_d.delete(); q_c.delete();
      in_frame = 1'b0; m_d = 1'b0; m_c = 1'b0;
    end else begin
      if (!in_frame && go) begin
        f = {a, d};
        for (int k = 14; k >= 0; k--) begin
          q_d.push_back(f[k]); q_c.push_back(1'b0);
          q_d.push_back(f[k]); q_c.push_back(1'b1);
        end
      end
      if (q_d.size() > 0) begin
        m_d = q_d.pop_front(); m_c = q_c.pop_front(); in_frame = 1'b1;
      end else begin
        m_d = 1'b0; m_c = 1'b0; in_frame = 1'b0;
      end
    end
    #1;
    check("model_outd", OutD, m_d);
    check("model_outc", OutC, m_c);
  endtask

  // Runs n cycles with Go=0 and shifts OutD into bits at each strobe-high cycle.
  task automatic run_collect(input int n, inout logic [14:0] bits, inout int pulses);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 7'h00, 8'h00);
      if (OutC) begin bits = {bits[13:0], OutD}; pulses++; end
    end
  endtask

  typedef struct {
    logic       rst, go;
    logic [6:0] a;
    logic [7:0] d;
    logic       exp_d, exp_c;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [14:0] bits;
    int          pulses;

    tbl[0] = '{1'b1, 1'b1, 7'h7F, 8'hFF, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 7'h7F, 8'hFF, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 7'h41, 8'h9F, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].go, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_outd", i), OutD, tbl[i].exp_d);
      check($sformatf("tbl%0d_outc", i), OutC, tbl[i].exp_c);
    end
    // Finish that frame (cycles 6..30) and idle a couple of cycles.
    for (int i = 0; i < 27; i++) step(1'b0, 1'b0, 7'h00, 8'h00);
    check("tbl_frame_end_outc", OutC, 1'b0);

    // All-ones frame: OutD high for 30 cycles, alternating strobe, then 300 ns idle.
    step(1'b0, 1'b1, 7'h7F, 8'hFF);
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) step(1'b0, 1'b0, 7'h00, 8'h00);
      check("ones_outd", OutD, 1'b1);
      check("ones_outc", OutC, logic'(i % 2 == 0));
      if (OutC) pulses++;
    end
    check("ones_pulses15", logic'(pulses == 15), 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 7'h00, 8'h00);
      check("ones_idle_outd", OutD, 1'b0);
      check("ones_idle_outc", OutC, 1'b0);
    end

    // Bit order.
    step(1'b0, 1'b1, 7'b1000001, 8'b10011111);
    bits = 15'(OutC ? OutD : 1'b0); pulses = 0; bits = '0;
    run_collect(29, bits, pulses);
    check("order_bits", logic'(bits == 15'b100000110011111), 1'b1);
    if (bits != 15'b100000110011111) $display("  bits got %b", bits);
    check("order_pulses", logic'(pulses == 15), 1'b1);
    step(1'b0, 1'b0, 7'h00, 8'h00);
    check("order_idle_outc", OutC, 1'b0);

    // Go re-pulse mid-frame with different A/D must not restart.
    step(1'b0, 1'b1, 7'h2A, 8'hC3);
    bits = '0; pulses = 0;
    run_collect(8, bits, pulses);
    step(1'b0, 1'b1, 7'h00, 8'h00);
    if (OutC) begin bits = {bits[13:0], OutD}; pulses++; end
    run_collect(20, bits, pulses);
    check("repulse_bits", logic'(bits == {7'h2A, 8'hC3}), 1'b1);
    check("repulse_pulses", logic'(pulses == 15), 1'b1);
    step(1'b0, 1'b0, 7'h00, 8'h00);

    // Reset at cycle 12 of a frame, then a clean frame.
    step(1'b0, 1'b1, 7'h7F, 8'hFF);
    for (int i = 2; i < 12; i++) step(1'b0, 1'b0, 7'h00, 8'h00);
    step(1'b1, 1'b1, 7'h7F, 8'hFF);
    check("midrst_outd", OutD, 1'b0);
    check("midrst_outc", OutC, 1'b0);
    step(1'b0, 1'b0, 7'h00, 8'h00);
    check("postrst_idle", OutD | OutC, 1'b0);
    step(1'b0, 1'b1, 7'h33, 8'h5A);
    bits = '0; pulses = 0;
    run_collect(29, bits, pulses);
    check("postrst_bits", logic'(bits == {7'h33, 8'h5A}), 1'b1);
    check("postrst_pulses", logic'(pulses == 15), 1'b1);
    step(1'b0, 1'b0, 7'h00, 8'h00);

    // Go held high 70 cycles: frames at 1..30, 32..61, 63.., idle at 31 and 62.
    bits = '0; pulses = 0;
    for (int i = 1; i <= 70; i++) begin
      step(1'b0, 1'b1, 7'h55, 8'hA5);
      if (OutC) begin pulses++; if (i <= 30) bits = {bits[13:0], OutD}; end
      if (i == 31 || i == 62) check("held_gap", OutD | OutC, 1'b0);
      if (i == 32 || i == 63) check("held_restart_outc", OutC, 1'b0);
      if (i == 33 || i == 64) check("held_restart_strobe", OutC, 1'b1);
    end
    check("held_bits", logic'(bits == {7'h55, 8'hA5}), 1'b1);
    check("held_pulses34", logic'(pulses == 34), 1'b1);
    step(1'b1, 1'b0, 7'h00, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 5) == 0),
           7'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
